laser_pwm_sequencer: RTL and testbench
======================================

Name: laser_pwm_sequencer

Overview:
Sequences the laser diode drive on pico2-ice as a fixed-rate 400 Hz PWM with a 256-step compare value.
- Accepts duty updates over a valid/ready handshake and applies them only at period boundaries (glitch-free).
- Soft-starts by ramping duty from 0 to the target.
- Drops to a latched FAULT state when the interlock opens.
- Sits between the future SPI register block and the ICE_46 laser pin.

Parameters:
- CLOCK_FREQUENCY, 48_000_000: input clock in Hz.
- PWM_FREQUENCY, 400: PWM refresh rate in Hz.
- DUTY_WIDTH, 8: compare width; 2**DUTY_WIDTH slots per period.
- RAMP_STEP, 16: duty increment per period in RAMP.
- MAX_ON_PERIODS, 4000: watchdog limit in periods (10 s); used only with the optional feature.

Ports:
- CLK  in  1  48 MHz clock.
- RST  in  1  synchronous reset, active-high.
- ENABLE  in  1  request laser run; level-sensitive.
- INTERLOCK  in  1  1 = safe; 0 forces FAULT.
- FAULT_CLR  in  1  single-cycle pulse that clears a latched fault.
- CFG_VALID  in  1  duty update offered.
- CFG_READY  out  1  update can be accepted.
- CFG_DUTY  in  DUTY_WIDTH  target compare value.
- LASER_OUT  out  1  laser drive, active-high.
- LED_G  out  1  status LED, active-low; lit while the laser is running.
- PERIOD_START  out  1  one-cycle pulse at slot 0 of each period.
- FAULT  out  1  latched fault flag.

Behaviour:
Reset:
- On RST=1: LASER_OUT=0, LED_G=1, PERIOD_START=0, FAULT=0, CFG_READY=1, state=IDLE.
- All counters, target duty, active duty and pending registers clear to 0.

Timebase:
- STEP_CYCLES = CLOCK_FREQUENCY / (PWM_FREQUENCY * 2**DUTY_WIDTH), integer division; default 468.
- Prescaler counts 0..STEP_CYCLES-1; slot counter advances 0..255 on each prescaler wrap and wraps 255->0.
- Period = 468*256 = 119808 clocks.
- PERIOD_START pulses for one cycle when slot=0 and prescaler=0, in every state except IDLE. Counters are held at 0 in IDLE.

PWM output:
- LASER_OUT is registered and equals (slot < active_duty) in RAMP/RUN; it is 0 in all other states.
- 1 clock latency from the counters.
- duty 0 gives a constant low output; maximum duty is 255/256.

Config handshake:
- Transfer occurs when CFG_VALID && CFG_READY; CFG_DUTY is captured into the pending register and CFG_READY drops the next cycle.
- At the next period boundary, pending copies to target and CFG_READY rises.
- In IDLE or FAULT, the update is applied to target immediately and CFG_READY stays 1.
- If a transfer and a period boundary occur in the same cycle, the boundary applies the old pending value first; the new value waits for the following boundary.

State machine:
- IDLE -> RAMP: ENABLE=1 and INTERLOCK=1. active_duty=0, counters start.
- RAMP: at each boundary, active_duty = min(active_duty+RAMP_STEP, target), computed with saturating arithmetic at DUTY_WIDTH+1 bits.
- RAMP -> RUN: active_duty equals target at a boundary.
- RUN: a target change is applied as a direct step at the boundary; there is no re-ramp.
- RUN/RAMP -> IDLE: ENABLE=0. LASER_OUT=0 on the next cycle, no wait for the boundary; active_duty clears.
- any non-IDLE state -> FAULT: INTERLOCK=0, which overrides ENABLE. LASER_OUT=0 on the next cycle; FAULT=1.
- A FAULT request while in IDLE also latches FAULT.
- FAULT -> IDLE: FAULT_CLR=1 and ENABLE=0 and INTERLOCK=1. FAULT_CLR is ignored otherwise.

Boundary cases:
- Target lowered below active_duty during RAMP: active_duty takes target at the next boundary, then state goes to RUN.
- RST mid-period: full reset with no residual pulse.

LED_G = ~(state==RAMP || state==RUN), registered.

Optional Feature:
- Macro: LASER_WATCHDOG_EN.
- With it defined: a period counter increments at each boundary while in RAMP/RUN and clears on IDLE entry. Reaching MAX_ON_PERIODS forces FAULT exactly as an interlock trip does.
- Without it: no counter and no timeout; MAX_ON_PERIODS is unused.

Decomposition:
- Package laser_pkg holds:
  - the state enum typedef (IDLE, RAMP, RUN, FAULT);
  - the DUTY_WIDTH-based duty_t typedef;
  - the STEP_CYCLES derivation function.
- Sub-module pwm_timebase holds the prescaler, slot counter and PERIOD_START generation, with an enable/clear input.
- The sequencer FSM, handshake and compare logic remain in the top.

Test Plan:
1. RST, set CFG_DUTY=128 in IDLE, ENABLE=1 -> active duty steps 16,32,...,128 over 8 periods; LASER_OUT high 128*468 clocks out of each 119808; then RUN.
2. In RUN, send CFG_DUTY=64 mid-period -> CFG_READY low until the next PERIOD_START; the new width of 64*468 clocks begins exactly at that boundary.
3. In RUN, drop INTERLOCK for 1 cycle -> LASER_OUT=0 and FAULT=1 the next cycle; FAULT_CLR with ENABLE=1 is ignored; FAULT_CLR with ENABLE=0 returns to IDLE.
4. ENABLE=0 mid-pulse at slot 40 with duty 128 -> LASER_OUT falls the next cycle; LED_G=1.
5. CFG_DUTY=0, ENABLE=1 -> LASER_OUT never asserts; PERIOD_START still every 119808 clocks.
6. With LASER_WATCHDOG_EN and MAX_ON_PERIODS=3 -> FAULT asserts at the 3rd boundary after leaving IDLE. Without the macro -> no fault after 10 periods.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and timebase arithmetic for the laser PWM sequencer.
package laser_pkg;

   localparam int unsigned DefaultDutyWidth = 8;

   typedef logic [DefaultDutyWidth-1:0] duty_t;

   typedef enum logic [1:0] {
      StIdle,
      StRamp,
      StRun,
      StFault
   } state_t;

   // Clocks per PWM slot, clamped to 1 so a prescaler always exists.
   function automatic int unsigned step_cycles(input int unsigned clk_hz,
                                               input int unsigned pwm_hz,
                                               input int unsigned duty_w);
      int unsigned steps;
      steps = clk_hz / (pwm_hz << duty_w);
      return (steps == 0) ? 1 : steps;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, slot counter and registered period-start pulse.
// Counters are held at zero whenever i_en is low.
module pwm_timebase #(
   parameter int unsigned STEP_CYCLES = 468,
   parameter int unsigned DUTY_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   output logic [DUTY_WIDTH-1:0] o_slot,
   output logic                  o_boundary,
   output logic                  o_period_start
);

   localparam int unsigned PrescWidth = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PrescWidth-1:0] PrescLast = PrescWidth'(STEP_CYCLES - 1);

   logic [PrescWidth-1:0] r_presc;
   logic [DUTY_WIDTH-1:0] r_slot;
   logic                  r_period_start;
   logic                  w_presc_wrap;

   assign w_presc_wrap   = (r_presc == PrescLast);
   assign o_boundary     = i_en && (r_presc == '0) && (r_slot == '0);
   assign o_slot         = r_slot;
   assign o_period_start = r_period_start;

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         r_presc <= '0;
         r_slot  <= '0;
      end else if (w_presc_wrap) begin
         r_presc <= '0;
         r_slot  <= r_slot + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Registered so the pulse lines up with the registered laser output.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= o_boundary;
      end
   end

endmodule

// File: rtl/laser_pwm_sequencer.sv
// Laser diode PWM sequencer: soft-start ramp, boundary-aligned duty updates, latched fault.
// Define LASER_WATCHDOG_EN to trip FAULT after MAX_ON_PERIODS periods of continuous on-time.
module laser_pwm_sequencer
   import laser_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 48_000_000,
   parameter int unsigned PWM_FREQUENCY   = 400,
   parameter int unsigned DUTY_WIDTH      = DefaultDutyWidth,
   parameter int unsigned RAMP_STEP       = 16
`ifdef LASER_WATCHDOG_EN
   ,
   parameter int unsigned MAX_ON_PERIODS  = 4000
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic                  i_interlock,
   input  logic                  i_fault_clr,
   input  logic                  i_cfg_valid,
   output logic                  o_cfg_ready,
   input  logic [DUTY_WIDTH-1:0] i_cfg_duty,
   output logic                  o_laser_out,
   output logic                  o_led_g,
   output logic                  o_period_start,
   output logic                  o_fault
);

   localparam int unsigned StepCycles =
      step_cycles(CLOCK_FREQUENCY, PWM_FREQUENCY, DUTY_WIDTH);
   localparam logic [DUTY_WIDTH:0] RampInc = (DUTY_WIDTH + 1)'(RAMP_STEP);

   state_t                r_state, w_state_d;
   logic [DUTY_WIDTH-1:0] r_target, w_target_d;
   logic [DUTY_WIDTH-1:0] r_active, w_active_d;
   logic [DUTY_WIDTH-1:0] r_pending, w_pending_d;
   logic                  r_pend_full, w_pend_full_d;
   logic                  r_laser, r_led_g, r_fault;

   logic                  w_tb_en, w_boundary, w_xfer, w_running, w_running_d, w_wd_trip;
   logic [DUTY_WIDTH-1:0] w_slot, w_tgt_eff;
   logic [DUTY_WIDTH:0]   w_ramp_sum, w_ramp_val;

   assign w_tb_en = (r_state != StIdle);

   pwm_timebase #(
      .STEP_CYCLES (StepCycles),
      .DUTY_WIDTH  (DUTY_WIDTH)
   ) u_timebase (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_en           (w_tb_en),
      .o_slot         (w_slot),
      .o_boundary     (w_boundary),
      .o_period_start (o_period_start)
   );

   assign w_running   = (r_state == StRamp) || (r_state == StRun);
   assign w_running_d = (w_state_d == StRamp) || (w_state_d == StRun);
   assign w_xfer      = i_cfg_valid && !r_pend_full;
   // A pending update lands at the same boundary that consumes it.
   assign w_tgt_eff   = r_pend_full ? r_pending : r_target;
   assign w_ramp_sum  = {1'b0, r_active} + RampInc;
   assign w_ramp_val  = (w_ramp_sum > {1'b0, w_tgt_eff}) ? {1'b0, w_tgt_eff} : w_ramp_sum;

`ifdef LASER_WATCHDOG_EN
   localparam int unsigned WdWidth = $clog2(MAX_ON_PERIODS + 1);
   localparam logic [WdWidth-1:0] WdLast = WdWidth'(MAX_ON_PERIODS - 1);

   logic [WdWidth-1:0] r_wd_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || (r_state == StIdle)) begin
         r_wd_cnt <= '0;
      end else if (w_running && w_boundary) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end

   assign w_wd_trip = w_running && w_boundary && (r_wd_cnt == WdLast);
`else
   assign w_wd_trip = 1'b0;
`endif

   always_comb begin
      w_state_d     = r_state;
      w_target_d    = r_target;
      w_active_d    = r_active;
      w_pending_d   = r_pending;
      w_pend_full_d = r_pend_full;

      if (w_running) begin
         if (w_boundary && r_pend_full) begin
            w_target_d    = r_pending;
            w_pend_full_d = 1'b0;
         end
         if (w_xfer) begin
            w_pending_d   = i_cfg_duty;
            w_pend_full_d = 1'b1;
         end
      end else if (r_pend_full) begin
         w_target_d    = r_pending;
         w_pend_full_d = 1'b0;
      end else if (i_cfg_valid) begin
         w_target_d = i_cfg_duty;
      end

      unique case (r_state)
         StIdle: begin
            w_active_d = '0;
            if (!i_interlock) begin
               w_state_d = StFault;
            end else if (i_enable) begin
               w_state_d = StRamp;
            end
         end
         StRamp, StRun: begin
            if (!i_interlock || w_wd_trip) begin
               w_state_d  = StFault;
               w_active_d = '0;
            end else if (!i_enable) begin
               w_state_d  = StIdle;
               w_active_d = '0;
            end else if (w_boundary) begin
               if (r_state == StRun) begin
                  w_active_d = w_tgt_eff;
               end else begin
                  w_active_d = w_ramp_val[DUTY_WIDTH-1:0];
                  if (w_ramp_val == {1'b0, w_tgt_eff}) begin
                     w_state_d = StRun;
                  end
               end
            end
         end
         StFault: begin
            w_active_d = '0;
            if (i_fault_clr && !i_enable && i_interlock) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d  = StIdle;
            w_active_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_target    <= '0;
         r_active    <= '0;
         r_pending   <= '0;
         r_pend_full <= 1'b0;
         r_laser     <= 1'b0;
         r_led_g     <= 1'b1;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_target    <= w_target_d;
         r_active    <= w_active_d;
         r_pending   <= w_pending_d;
         r_pend_full <= w_pend_full_d;
         // Compare against next duty so a new width starts on the period-start cycle.
         r_laser     <= w_running_d && (w_slot < w_active_d);
         r_led_g     <= !w_running_d;
         r_fault     <= (w_state_d == StFault);
      end
   end

   assign o_cfg_ready = !r_pend_full;
   assign o_laser_out = r_laser;
   assign o_led_g     = r_led_g;
   assign o_fault     = r_fault;

endmodule

// File: tb/tb_laser_pwm_sequencer.sv
// Bench for laser_pwm_sequencer with the timebase shrunk to 2 clocks per slot (512-clock period).
module tb_laser_pwm_sequencer;

   localparam int Step  = 2;
   localparam int Per   = Step * 256;
   localparam int Limit = 2 * Per;

   logic       clk = 1'b0;
   logic       rst, enable, interlock, fault_clr, cfg_valid;
   logic [7:0] cfg_duty;
   logic       o_cfg_ready, o_laser_out, o_led_g, o_period_start, o_fault;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       en, il, clr, vld;
      logic [7:0] duty;
      int         n;
      logic       laser, led, fault, ready;
   } vec_t;

   vec_t vecs[15];

   always #5 clk = ~clk;

   laser_pwm_sequencer #(
      .CLOCK_FREQUENCY (204_800),
      .PWM_FREQUENCY   (400),
      .DUTY_WIDTH      (8),
      .RAMP_STEP       (16)
`ifdef LASER_WATCHDOG_EN
      ,
      .MAX_ON_PERIODS  (3)
`endif
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (enable),
      .i_interlock    (interlock),
      .i_fault_clr    (fault_clr),
      .i_cfg_valid    (cfg_valid),
      .o_cfg_ready    (o_cfg_ready),
      .i_cfg_duty     (cfg_duty),
      .o_laser_out    (o_laser_out),
      .o_led_g        (o_led_g),
      .o_period_start (o_period_start),
      .o_fault        (o_fault)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send_cfg(input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_duty  = d;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ps(input string name);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (o_period_start !== 1'b1 && n < Limit);
      chk({name, " period_start"}, o_period_start, 1);
   endtask

   // Starts on a period-start cycle, ends on the next one.
   task automatic measure(input string name, input int exp_hi);
      int hi  = 0;
      int len = 0;
      do begin
         if (o_laser_out === 1'b1) hi++;
         len++;
         tick(1);
      end while (o_period_start !== 1'b1 && len < Limit);
      chk({name, " high"}, hi, exp_hi);
      chk({name, " len"}, len, Per);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         enable    = vecs[i].en;
         interlock = vecs[i].il;
         fault_clr = vecs[i].clr;
         cfg_valid = vecs[i].vld;
         cfg_duty  = vecs[i].duty;
         tick(vecs[i].n);
         chk($sformatf("row%0d laser", i), o_laser_out, vecs[i].laser);
         chk($sformatf("row%0d led", i), o_led_g, vecs[i].led);
         chk($sformatf("row%0d fault", i), o_fault, vecs[i].fault);
         chk($sformatf("row%0d ready", i), o_cfg_ready, vecs[i].ready);
      end
      fault_clr = 1'b0;
      cfg_valid = 1'b0;
   endtask

   initial begin
      int hi, rl, cnt;
      //           en    il    clr   vld   duty    n  laser led   fault ready
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   2, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   3, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd200, 1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd128, 1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd128, 2, 1'b0, 1'b1, 1'b0, 1'b1};
      // Interlock trip from RUN and fault-clear qualification.
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   2, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; enable = 1'b0; interlock = 1'b1; fault_clr = 1'b0;
      cfg_valid = 1'b0; cfg_duty = 8'd0;
      tick(3);
      chk("reset laser", o_laser_out, 0);
      chk("reset led", o_led_g, 1);
      chk("reset period_start", o_period_start, 0);
      chk("reset fault", o_fault, 0);
      chk("reset ready", o_cfg_ready, 1);
      rst = 1'b0;

      run_rows(0, 8);

`ifdef LASER_WATCHDOG_EN
      enable = 1'b1;
      wait_ps("wd1");
      chk("wd1 fault", o_fault, 0);
      wait_ps("wd2");
      chk("wd2 fault", o_fault, 0);
      wait_ps("wd3");
      chk("wd3 fault", o_fault, 1);
      chk("wd3 laser", o_laser_out, 0);
`else
      // Soft start 16..128 then RUN.
      enable = 1'b1;
      tick(1);
      chk("start led", o_led_g, 0);
      chk("start laser", o_laser_out, 0);
      wait_ps("ramp start");
      for (int k = 1; k <= 8; k++) measure($sformatf("ramp%0d", k), 32 * k);
      measure("run128", 256);

      // Mid-period update waits for the boundary.
      hi = 0; rl = 0;
      for (int j = 0; j < Limit; j++) begin
         if (o_laser_out === 1'b1) hi++;
         if (o_cfg_ready !== 1'b1) rl++;
         if (j == 101) chk("ready drop", o_cfg_ready, 0);
         if (j == 100) begin
            cfg_valid = 1'b1;
            cfg_duty  = 8'd64;
         end
         if (j == 101) cfg_valid = 1'b0;
         tick(1);
         if (o_period_start === 1'b1) break;
      end
      chk("upd boundary", o_period_start, 1);
      chk("upd old width", hi, 256);
      chk("ready low span", rl, 411);
      chk("ready at boundary", o_cfg_ready, 1);
      measure("upd new width", 128);

      // RUN applies a raised target as a direct step.
      send_cfg(8'd200);
      chk("ready busy", o_cfg_ready, 0);
      wait_ps("step");
      measure("run step", 400);

      tick(10);
      chk("pre-trip laser", o_laser_out, 1);
      run_rows(9, 14);

      // Enable drop mid-pulse at slot 40.
      send_cfg(8'd128);
      chk("idle cfg ready", o_cfg_ready, 1);
      enable = 1'b1;
      for (int k = 1; k <= 8; k++) wait_ps($sformatf("ramp2_%0d", k));
      tick(80);
      chk("slot40 laser", o_laser_out, 1);
      enable = 1'b0;
      tick(1);
      chk("disable laser", o_laser_out, 0);
      chk("disable led", o_led_g, 1);
      chk("disable fault", o_fault, 0);
      cnt = 0;
      for (int j = 0; j < 600; j++) begin
         tick(1);
         if (o_period_start === 1'b1) cnt++;
      end
      chk("idle no period_start", cnt, 0);

      // Duty 0 never drives the laser.
      send_cfg(8'd0);
      enable = 1'b1;
      wait_ps("zero start");
      chk("zero led", o_led_g, 0);
      for (int k = 1; k <= 3; k++) measure($sformatf("zero%0d", k), 0);
      enable = 1'b0;
      tick(2);

      // Target lowered below active during RAMP.
      send_cfg(8'd200);
      enable = 1'b1;
      for (int k = 1; k <= 3; k++) wait_ps($sformatf("ramp3_%0d", k));
      send_cfg(8'd20);
      wait_ps("lower");
      measure("lowered", 40);
      send_cfg(8'd100);
      wait_ps("after lower");
      measure("run after lower", 200);

      // Reset mid-period.
      tick(20);
      chk("pre-reset laser", o_laser_out, 1);
      rst = 1'b1;
      tick(1);
      chk("mid reset laser", o_laser_out, 0);
      chk("mid reset led", o_led_g, 1);
      chk("mid reset fault", o_fault, 0);
      chk("mid reset ready", o_cfg_ready, 1);
      chk("mid reset period_start", o_period_start, 0);
      cnt = 0;
      for (int j = 0; j < 600; j++) begin
         tick(1);
         if (o_period_start === 1'b1 || o_laser_out === 1'b1) cnt++;
      end
      chk("reset held quiet", cnt, 0);
      enable = 1'b0;
      rst    = 1'b0;
      tick(2);

      // No watchdog in this build.
      enable = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         wait_ps($sformatf("nowd%0d", k));
         if (o_fault === 1'b1) cnt++;
      end
      chk("no watchdog fault", cnt, 0);
      chk("no watchdog led", o_led_g, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
